uart_lite_ctrl: RTL and testbench
=================================

Name: uart_lite_ctrl

Overview:
AXI4-Lite master that sequences the UART Lite core on behalf of two requesters: the CPU "in" path (receive one byte) and "out" path (send one byte). After reset it clears both UART FIFOs once. It then polls the STAT register before every data access, so no read hits an empty RX FIFO and no write hits a full TX FIFO. Simultaneous requests are arbitrated round-robin, and SLVERR responses are retried a bounded number of times.

Parameters:
MAX_RETRY, 3, SLVERR retries per data access before the operation completes with error
POLL_GAP, 4, idle cycles inserted after a failed status poll before re-arbitration (0 allowed)

Ports:
CLK  in  1  clock (same clock as the UART core's s_axi_aclk)
RSTN  in  1  asynchronous active-low reset
in_req  in  1  level; requester wants one RX byte; held until in_ack
in_ack  out  1  one-cycle pulse; in_data/in_err valid this cycle
in_data  out  8  received byte (rdata[7:0])
in_err  out  1  with in_ack: read failed after retries, in_data=0
out_req  in  1  level; held until out_ack
out_data  in  8  byte to send; stable while out_req=1
out_ack  out  1  one-cycle pulse; byte accepted or failed
out_err  out  1  with out_ack: write failed after retries
awaddr  out  4  AXI write address
awvalid/awready  out/in  1  AXI AW handshake
wdata  out  32  {24'h0, byte}
wstrb  out  4  constant 4'b0001
wvalid/wready  out/in  1  AXI W handshake
bresp  in  2  00 OKAY, 10 SLVERR
bvalid/bready  in/out  1  AXI B handshake
araddr  out  4  AXI read address
arvalid/arready  out/in  1  AXI AR handshake
rdata  in  32  read data
rresp  in  2  00 OKAY, 10 SLVERR
rvalid/rready  in/out  1  AXI R handshake
busy  out  1  high in any state other than IDLE

Behaviour:
- Register map: RX 0x0, TX 0x4, STAT 0x8, CTRL 0xC. STAT bit0 = RX valid, bit3 = TX full.
- Reset (async assert, sync deassert handled externally): state INIT. All valid/ack/err outputs are 0; bready=0, rready=0, in_data=0, addresses=0, retry count=0, round-robin pointer=IN.
- INIT: write CTRL = 32'h3 (reset TX and RX FIFOs). Then INIT_B. On B handshake go to IDLE, whatever bresp is. This runs exactly once per reset.
- Write protocol (INIT, WR):
  - Assert awvalid and wvalid together in the same cycle.
  - Each drops independently on its own handshake. The state leaves only when both handshakes have completed.
  - Then assert bready until bvalid.
- Read protocol (STAT, RD):
  - Assert arvalid until arready.
  - Then assert rready until rvalid; capture rdata and rresp on the R handshake.
- Valid signals never drop before their handshake completes. Address and data stay stable while valid is high.
- IDLE arbitration:
  - Only one requester pending: select it.
  - Both pending: select the one the pointer indicates, then flip the pointer to the other.
  - Neither pending: stay in IDLE.
- POLL: read STAT.
  - IN op with bit0=1 → RD. OUT op with bit3=0 → WR.
  - Otherwise → WAIT for POLL_GAP cycles, then IDLE. The request stays pending and is re-arbitrated.
- RD: read 0x0.
  - rresp=00: in_data=rdata[7:0], pulse in_ack with in_err=0, → IDLE.
  - rresp=10: retry count < MAX_RETRY → increment and redo RD directly, without re-polling. Otherwise pulse in_ack with in_err=1 and in_data=0.
- WR: write 0x4 with out_data, with the same retry and error rules driven by bresp. The ack is out_ack/out_err.
- The retry count clears whenever an operation completes.
- A STAT read returning SLVERR counts as a failed poll (→ WAIT). It is never retried as an error.
- A requester that drops its req mid-operation still receives its ack pulse. Requesters must ignore an ack they did not request.
- Latency: with a zero-wait slave, IN from req to in_ack is 6 cycles (IDLE, STAT AR, STAT R, RD AR, RD R, ack). OUT is the same, with the write phases replacing the read phases.
- RSTN asserted mid-transaction: every valid drops immediately and no ack is issued. After release the block restarts at INIT.

Test Plan:
- Reset release with zero-wait slave → one write, awaddr=0xC, wdata=32'h3, wstrb=4'b0001; busy=0 afterwards; no ack pulses.
- in_req=1, STAT=0x01, RX rdata=32'h41 → in_ack 6 cycles after req with in_data=8'h41, in_err=0; exactly two AR handshakes (0x8, then 0x0).
- out_req=1, out_data=8'h5A, STAT=0x08 for 3 polls then 0x00 → 4 STAT reads with POLL_GAP gaps, one write to 0x4 with wdata=32'h5A, single out_ack.
- in_req and out_req asserted in the same cycle, both ready → IN serviced first, then OUT; repeat → OUT first (pointer alternates).
- Write with bresp=10 on every attempt → 4 write attempts (1+MAX_RETRY), then out_ack with out_err=1; next request starts with retry count 0.
- AW accepted 2 cycles before W, and RSTN pulsed mid-RD → valids held until their own handshake, no early drop; after reset all outputs are 0, INIT write reissued, no in_ack.

Source files
------------

// File: rtl/uart_lite_ctrl.sv
// AXI4-Lite master that drives a UART Lite core for one RX requester and one TX requester.
// Clears both FIFOs once after reset, polls STAT before each data access and retries SLVERR.
module uart_lite_ctrl #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        in_req,
  output logic        in_ack,
  output logic [7:0]  in_data,
  output logic        in_err,
  input  logic        out_req,
  input  logic [7:0]  out_data,
  output logic        out_ack,
  output logic        out_err,
  output logic [3:0]  awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        busy
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam int unsigned GW = $clog2(POLL_GAP + 2);
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GapLoad  = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;

  localparam logic [3:0] AddrRx   = 4'h0;
  localparam logic [3:0] AddrTx   = 4'h4;
  localparam logic [3:0] AddrStat = 4'h8;
  localparam logic [3:0] AddrCtrl = 4'hC;
  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic [3:0] {
    StInit, StInitWr, StInitB, StIdle, StPollAr, StPollR, StWait,
    StRdAr, StRdR, StWrAw, StWrB, StAck
  } state_e;

  state_e          state_q, state_d;
  logic            op_q, op_d;      // 0: IN (read RX), 1: OUT (write TX)
  logic            ptr_q, ptr_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic [3:0]      awaddr_q, awaddr_d;
  logic [3:0]      araddr_q, araddr_d;
  logic [7:0]      wbyte_q, wbyte_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            err_q, err_d;
  logic            wr_phase_done;
  logic            unused_rdata;

  assign unused_rdata = ^rdata[31:8];

  // AW and W complete independently; the phase ends once neither is still outstanding.
  assign wr_phase_done = (!awvalid_q || awready) && (!wvalid_q || wready);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wbyte_d   = wbyte_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;

    unique case (state_q)
      StInit: begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        awaddr_d  = AddrCtrl;
        wbyte_d   = 8'h03;
        state_d   = StInitWr;
      end
      StInitWr, StWrAw: begin
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if (wr_phase_done) state_d = (state_q == StInitWr) ? StInitB : StWrB;
      end
      StInitB: begin
        if (bvalid) state_d = StIdle;
      end
      StIdle: begin
        if (in_req || out_req) begin
          if (in_req && out_req) begin
            op_d  = ptr_q;
            ptr_d = !ptr_q;
          end else begin
            op_d = out_req;
          end
          arvalid_d = 1'b1;
          araddr_d  = AddrStat;
          state_d   = StPollAr;
        end
      end
      StPollAr, StRdAr: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = (state_q == StPollAr) ? StPollR : StRdR;
        end
      end
      StPollR: begin
        if (rvalid) begin
          if (rresp == RespOkay && !op_q && rdata[0]) begin
            arvalid_d = 1'b1;
            araddr_d  = AddrRx;
            state_d   = StRdAr;
          end else if (rresp == RespOkay && op_q && !rdata[3]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = AddrTx;
            wbyte_d   = out_data;
            state_d   = StWrAw;
          end else if (POLL_GAP == 0) begin
            state_d = StIdle;
          end else begin
            gap_d   = GapLoad;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GW'(1);
      end
      StRdR: begin
        if (rvalid) begin
          if (rresp == RespOkay) begin
            rd_data_d = rdata[7:0];
            err_d     = 1'b0;
            retry_d   = '0;
            state_d   = StAck;
          end else if (retry_q < RetryMax) begin
            retry_d   = retry_q + RW'(1);
            arvalid_d = 1'b1;
            state_d   = StRdAr;
          end else begin
            rd_data_d = 8'h00;
            err_d     = 1'b1;
            retry_d   = '0;
            state_d   = StAck;
          end
        end
      end
      StWrB: begin
        if (bvalid) begin
          if (bresp == RespOkay) begin
            err_d   = 1'b0;
            retry_d = '0;
            state_d = StAck;
          end else if (retry_q < RetryMax) begin
            retry_d   = retry_q + RW'(1);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrAw;
          end else begin
            err_d   = 1'b1;
            retry_d = '0;
            state_d = StAck;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= StInit;
      op_q      <= 1'b0;
      ptr_q     <= 1'b0;
      retry_q   <= '0;
      gap_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= 4'h0;
      araddr_q  <= 4'h0;
      wbyte_q   <= 8'h00;
      rd_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ptr_q     <= ptr_d;
      retry_q   <= retry_d;
      gap_q     <= gap_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wbyte_q   <= wbyte_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign arvalid = arvalid_q;
  assign awaddr  = awaddr_q;
  assign araddr  = araddr_q;
  assign wdata   = {24'h0, wbyte_q};
  assign wstrb   = 4'b0001;
  assign bready  = (state_q == StInitB) || (state_q == StWrB);
  assign rready  = (state_q == StPollR) || (state_q == StRdR);
  assign busy    = (state_q != StIdle);
  assign in_ack  = (state_q == StAck) && !op_q;
  assign out_ack = (state_q == StAck) && op_q;
  assign in_err  = in_ack && err_q;
  assign out_err = out_ack && err_q;
  assign in_data = rd_data_q;

endmodule

// File: tb/tb_uart_lite_ctrl.sv
// Directed bench for uart_lite_ctrl: a small AXI4-Lite UART slave model plus a handshake
// monitor; each task drives one scenario and checks hand-computed results.
module tb_uart_lite_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        in_req = 1'b0;
  logic        out_req = 1'b0;
  logic [7:0]  out_data = 8'h00;
  logic        in_ack, in_err, out_ack, out_err;
  logic [7:0]  in_data;
  logic [3:0]  awaddr, araddr, wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready, busy;
  logic [31:0] wdata;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  // Slave configuration, written by the test tasks.
  logic [31:0] stat_ok_val = 32'h01;
  logic [31:0] stat_fail_val = 32'h08;
  int          stat_fail_n = 0;
  logic [31:0] rx_val = 32'h41;
  int          rx_fail_n = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          w_delay = 0;

  // Monitor state.
  int          cyc = 0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, stat_reads, rx_reads;
  int          aw_hs_cyc, w_hs_cyc;
  logic [3:0]  last_awaddr, ar_addr_q;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;
  logic [3:0]  ar_log[$];
  logic        aw_pend, w_pend, ar_pend;
  logic [3:0]  aw_prev, ar_prev;
  logic [31:0] w_prev;
  int          viol = 0;
  int          in_ack_cnt = 0, out_ack_cnt = 0;

  int checks = 0;
  int errors = 0;

  uart_lite_ctrl dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_req(in_req), .in_ack(in_ack), .in_data(in_data), .in_err(in_err),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack), .out_err(out_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (in_ack)  in_ack_cnt  <= in_ack_cnt + 1;
    if (out_ack) out_ack_cnt <= out_ack_cnt + 1;
  end

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      stat_reads <= 0; rx_reads <= 0; aw_hs_cyc <= 0; w_hs_cyc <= 0;
      last_awaddr <= 4'h0; last_wdata <= 32'h0; last_wstrb <= 4'h0; ar_addr_q <= 4'h0;
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      aw_prev <= 4'h0; ar_prev <= 4'h0; w_prev <= 32'h0;
      ar_log.delete();
    end else begin
      if (awvalid && awready) begin
        aw_cnt <= aw_cnt + 1; last_awaddr <= awaddr; aw_hs_cyc <= cyc;
      end
      if (wvalid && wready) begin
        w_cnt <= w_cnt + 1; last_wdata <= wdata; last_wstrb <= wstrb; w_hs_cyc <= cyc;
      end
      if (bvalid && bready) b_cnt <= b_cnt + 1;
      if (arvalid && arready) begin
        ar_cnt <= ar_cnt + 1; ar_addr_q <= araddr; ar_log.push_back(araddr);
      end
      if (rvalid && rready) begin
        r_cnt <= r_cnt + 1;
        if (ar_addr_q == 4'h8) stat_reads <= stat_reads + 1;
        else                   rx_reads   <= rx_reads + 1;
      end
      // A valid left pending at the last edge must still be high with unchanged payload.
      if ((aw_pend && (!awvalid || awaddr != aw_prev)) || (w_pend && (!wvalid || wdata != w_prev))
          || (ar_pend && (!arvalid || araddr != ar_prev)))
        viol <= viol + 1;
      aw_pend <= awvalid && !awready; aw_prev <= awaddr;
      w_pend  <= wvalid && !wready;   w_prev  <= wdata;
      ar_pend <= arvalid && !arready; ar_prev <= araddr;
    end
  end

  int w_wait = 0;
  always @(negedge CLK) begin
    if (!RSTN) begin
      bvalid = 1'b0; rvalid = 1'b0; wready = 1'b0; w_wait = 0;
    end else begin
      awready = 1'b1;
      arready = 1'b1;
      if (wvalid && w_wait < w_delay) begin
        wready = 1'b0; w_wait++;
      end else begin
        wready = 1'b1;
        if (!wvalid) w_wait = 0;
      end
      bvalid = (aw_cnt > b_cnt) && (w_cnt > b_cnt);
      bresp  = bresp_cfg;
      rvalid = (ar_cnt > r_cnt);
      if (ar_addr_q == 4'h8) begin
        rdata = (stat_reads < stat_fail_n) ? stat_fail_val : stat_ok_val;
        rresp = 2'b00;
      end else begin
        rdata = rx_val;
        rresp = (rx_reads < rx_fail_n) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic wait_ack(input int bound, output int n, output logic ai, output logic ao,
                          output logic [7:0] d, output logic ie, output logic oe);
    n = -1; ai = 1'b0; ao = 1'b0; d = 8'h00; ie = 1'b0; oe = 1'b0;
    for (int i = 1; i <= bound && n < 0; i++) begin
      @(negedge CLK);
      if (in_ack || out_ack) begin
        n = i; ai = in_ack; ao = out_ack; d = in_data; ie = in_err; oe = out_err;
      end
    end
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int i = 1; i <= 60 && n < 0; i++) begin
      @(negedge CLK);
      if (!busy) n = i;
    end
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(negedge CLK);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, in_ack, out_ack, in_err, out_err} !== 9'b0)
      begin errors++; $display("FAIL reset_ctrl_outs: got %b want 0", {awvalid, wvalid,
        arvalid, bready, rready, in_ack, out_ack, in_err, out_err}); end
    checks++;
    if ({in_data, awaddr, araddr} !== 16'h0) begin
      errors++; $display("FAIL reset_data_addr: got %h want 0", {in_data, awaddr, araddr}); end
    RSTN = 1'b1;
    wait_idle(n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL init_done: busy stuck, want idle"); end
    checks++;
    if (aw_cnt !== 1 || w_cnt !== 1 || b_cnt !== 1) begin errors++;
      $display("FAIL init_write_count: aw %0d w %0d b %0d want 1", aw_cnt, w_cnt, b_cnt); end
    checks++;
    if (last_awaddr !== 4'hC || last_wdata !== 32'h3 || last_wstrb !== 4'b0001) begin errors++;
      $display("FAIL init_write: addr %h data %h strb %b want c 3 0001", last_awaddr,
               last_wdata, last_wstrb); end
    repeat (3) @(negedge CLK);
    checks++;
    if (in_ack_cnt + out_ack_cnt !== 0 || ar_cnt !== 0) begin errors++;
      $display("FAIL init_no_ack: acks %0d ar %0d want 0", in_ack_cnt + out_ack_cnt, ar_cnt); end
  endtask

  task automatic test_read;
    int n, base, acks0; logic ai, ao, ie, oe; logic [7:0] d;
    stat_ok_val = 32'h01; rx_val = 32'h41;
    base = ar_log.size(); acks0 = in_ack_cnt;
    in_req = 1'b1;
    wait_ack(50, n, ai, ao, d, ie, oe);
    in_req = 1'b0;
    checks++;
    if (n !== 5 || ai !== 1'b1 || ao !== 1'b0) begin errors++;
      $display("FAIL read_latency: cycles %0d in_ack %b out_ack %b want 5 1 0", n, ai, ao); end
    checks++;
    if (d !== 8'h41 || ie !== 1'b0) begin errors++;
      $display("FAIL read_data: data %h err %b want 41 0", d, ie); end
    checks++;
    if (ar_log.size() - base !== 2 || ar_log[base] !== 4'h8 || ar_log[base+1] !== 4'h0) begin
      errors++; $display("FAIL read_ar_seq: n %0d first %h second %h want 2 8 0",
                         ar_log.size() - base, ar_log[base], ar_log[base+1]); end
    repeat (4) @(negedge CLK);
    checks++;
    if (in_ack_cnt - acks0 !== 1 || busy !== 1'b0) begin errors++;
      $display("FAIL read_single_ack: acks %0d busy %b want 1 0", in_ack_cnt - acks0, busy); end
  endtask

  task automatic test_poll_wait;
    int n, st0, aw0, acks0; logic ai, ao, ie, oe; logic [7:0] d;
    stat_ok_val = 32'h00; stat_fail_val = 32'h08;
    st0 = stat_reads; aw0 = aw_cnt; acks0 = out_ack_cnt;
    stat_fail_n = stat_reads + 3;
    out_data = 8'h5A; out_req = 1'b1;
    wait_ack(100, n, ai, ao, d, ie, oe);
    out_req = 1'b0;
    checks++;
    if (n !== 26 || ao !== 1'b1 || oe !== 1'b0) begin errors++;
      $display("FAIL poll_latency: cycles %0d out_ack %b err %b want 26 1 0", n, ao, oe); end
    checks++;
    if (stat_reads - st0 !== 4 || aw_cnt - aw0 !== 1) begin errors++;
      $display("FAIL poll_counts: stat %0d writes %0d want 4 1", stat_reads - st0, aw_cnt - aw0);
    end
    checks++;
    if (last_awaddr !== 4'h4 || last_wdata !== 32'h5A) begin errors++;
      $display("FAIL poll_write: addr %h data %h want 4 5a", last_awaddr, last_wdata); end
    repeat (3) @(negedge CLK);
    checks++;
    if (out_ack_cnt - acks0 !== 1) begin errors++;
      $display("FAIL poll_single_ack: got %0d want 1", out_ack_cnt - acks0); end
    stat_fail_n = 0; stat_ok_val = 32'h01;
  endtask

  task automatic test_back_to_back;
    int n; logic ai, ao, ie, oe; logic [7:0] d;
    rx_val = 32'h41; out_data = 8'hC3;
    for (int r = 0; r < 2; r++) begin
      in_req = 1'b1; out_req = 1'b1;
      wait_ack(50, n, ai, ao, d, ie, oe);
      checks++;
      if (ai !== (r == 0) || ao !== (r == 1)) begin errors++;
        $display("FAIL arb_first_r%0d: in_ack %b out_ack %b want %b %b", r, ai, ao, r == 0,
                 r == 1); end
      if (ai) in_req = 1'b0;
      if (ao) out_req = 1'b0;
      wait_ack(50, n, ai, ao, d, ie, oe);
      checks++;
      if (ai !== (r == 1) || ao !== (r == 0)) begin errors++;
        $display("FAIL arb_second_r%0d: in_ack %b out_ack %b want %b %b", r, ai, ao, r == 1,
                 r == 0); end
      in_req = 1'b0; out_req = 1'b0;
      checks++;
      if (last_wdata !== 32'hC3) begin errors++;
        $display("FAIL arb_wdata_r%0d: got %h want c3", r, last_wdata); end
      @(negedge CLK);
    end
  endtask

  task automatic test_write_retry;
    int n, aw0, st0; logic ai, ao, ie, oe; logic [7:0] d;
    bresp_cfg = 2'b10; out_data = 8'h77;
    for (int r = 0; r < 2; r++) begin
      aw0 = aw_cnt; st0 = stat_reads;
      out_req = 1'b1;
      wait_ack(100, n, ai, ao, d, ie, oe);
      out_req = 1'b0;
      checks++;
      if (ao !== 1'b1 || oe !== 1'b1) begin errors++;
        $display("FAIL wr_err_r%0d: out_ack %b out_err %b want 1 1", r, ao, oe); end
      checks++;
      if (aw_cnt - aw0 !== 4 || stat_reads - st0 !== 1) begin errors++;
        $display("FAIL wr_attempts_r%0d: writes %0d polls %0d want 4 1", r, aw_cnt - aw0,
                 stat_reads - st0); end
      @(negedge CLK);
    end
    bresp_cfg = 2'b00;
  endtask

  task automatic test_read_retry;
    int n, ar0; logic ai, ao, ie, oe; logic [7:0] d;
    rx_val = 32'hFF5C;
    ar0 = ar_cnt; rx_fail_n = rx_reads + 2;
    in_req = 1'b1;
    wait_ack(100, n, ai, ao, d, ie, oe);
    in_req = 1'b0;
    checks++;
    if (ai !== 1'b1 || ie !== 1'b0 || d !== 8'h5C || ar_cnt - ar0 !== 4) begin errors++;
      $display("FAIL rd_retry_ok: ack %b err %b data %h ar %0d want 1 0 5c 4", ai, ie, d,
               ar_cnt - ar0); end
    @(negedge CLK);
    ar0 = ar_cnt; rx_fail_n = rx_reads + 100;
    in_req = 1'b1;
    wait_ack(100, n, ai, ao, d, ie, oe);
    in_req = 1'b0;
    checks++;
    if (ai !== 1'b1 || ie !== 1'b1 || d !== 8'h00 || ar_cnt - ar0 !== 5) begin errors++;
      $display("FAIL rd_retry_fail: ack %b err %b data %h ar %0d want 1 1 00 5", ai, ie, d,
               ar_cnt - ar0); end
    rx_fail_n = 0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int n, acks0, found; logic ai, ao, ie, oe; logic [7:0] d;
    w_delay = 2; out_data = 8'h99; out_req = 1'b1;
    wait_ack(100, n, ai, ao, d, ie, oe);
    out_req = 1'b0; w_delay = 0;
    checks++;
    if (ao !== 1'b1 || oe !== 1'b0 || last_wdata !== 32'h99) begin errors++;
      $display("FAIL slow_w_write: ack %b err %b data %h want 1 0 99", ao, oe, last_wdata); end
    checks++;
    if (w_hs_cyc - aw_hs_cyc !== 2) begin errors++;
      $display("FAIL slow_w_gap: got %0d want 2", w_hs_cyc - aw_hs_cyc); end
    checks++;
    if (viol !== 0) begin errors++;
      $display("FAIL valid_stability: got %0d violations want 0", viol); end
    @(negedge CLK);
    acks0 = in_ack_cnt + out_ack_cnt;
    in_req = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge CLK);
      if (arvalid && araddr == 4'h0) found = 1;
    end
    checks++;
    if (found !== 1) begin errors++; $display("FAIL mid_rd_reached: got 0 want 1"); end
    RSTN = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, in_ack, out_ack, in_err, out_err} !== 9'b0)
      begin errors++; $display("FAIL mid_reset_outs: got %b want 0", {awvalid, wvalid,
        arvalid, bready, rready, in_ack, out_ack, in_err, out_err}); end
    checks++;
    if ({in_data, awaddr, araddr} !== 16'h0) begin errors++;
      $display("FAIL mid_reset_data: got %h want 0", {in_data, awaddr, araddr}); end
    in_req = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    wait_idle(n);
    checks++;
    if (n < 0 || aw_cnt !== 1 || last_awaddr !== 4'hC || last_wdata !== 32'h3) begin errors++;
      $display("FAIL reinit: idle %0d aw %0d addr %h data %h want >0 1 c 3", n, aw_cnt,
               last_awaddr, last_wdata); end
    repeat (4) @(negedge CLK);
    checks++;
    if (in_ack_cnt + out_ack_cnt !== acks0) begin errors++;
      $display("FAIL mid_reset_no_ack: got %0d want %0d", in_ack_cnt + out_ack_cnt, acks0); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_poll_wait();
    test_back_to_back();
    test_write_retry();
    test_read_retry();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
